// File: rtl/instr_encoder.sv
// Program-load encoder: packs symbolic RV32I instructions into machine words and writes them to imem.
// Latency: an accept in cycle N drives mem_we/mem_addr/mem_wdata in cycle N+1; count follows one cycle later.
// Backpressure: in_ready is high only in LOAD, so it drops once done, error or overflow is reached.
// Ports: clk/reset (sync, active high); start; in_valid/in_ready/in_last with op/rd/rs1/rs2/imm fields;
//        mem_we/mem_addr/mem_wdata write port; busy/done/err/err_code status; count = words written.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;

  // Write pointer value at which the next word lands on the last memory slot.
  localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     wptr_q, wptr_d;     // address of the next accepted word
  logic [ADDR_W:0]     count_q, count_d;   // words actually written (lags wptr by one cycle)
  logic [1:0]          err_code_q, err_code_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;

  logic [31:0] enc_word;
  logic [2:0]  f3;
  logic        op_ok, imm_ok;
  logic        i_ok, b_ok, j_ok;
  logic        accept;

  // Signed-range checks: the value fits when every bit above the field's sign bit matches it.
  assign i_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign b_ok = !imm[0] && ((imm[31:12] == '0) || (imm[31:12] == '1));
  assign j_ok = !imm[0] && ((imm[31:20] == '0) || (imm[31:20] == '1));

  always_comb begin
    f3 = 3'd0;
    case (op)
      6'd2, 6'd11, 6'd22, 6'd29:                f3 = 3'd4;
      6'd3, 6'd12, 6'd31:                       f3 = 3'd6;
      6'd4, 6'd13, 6'd32:                       f3 = 3'd7;
      6'd5, 6'd14, 6'd20, 6'd25, 6'd28:         f3 = 3'd1;
      6'd6, 6'd7, 6'd15, 6'd16, 6'd23, 6'd30:   f3 = 3'd5;
      6'd8, 6'd17, 6'd21, 6'd26:                f3 = 3'd2;
      6'd9, 6'd18:                              f3 = 3'd3;
      default:                                  f3 = 3'd0;
    endcase
  end

  always_comb begin
    enc_word = '0;
    op_ok    = 1'b1;
    imm_ok   = 1'b1;
    if (op <= 6'd9) begin
      enc_word = {((op == 6'd1) || (op == 6'd7)) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'b0110011};
    end else if ((op <= 6'd13) || (op == 6'd17) || (op == 6'd18)) begin
      imm_ok   = i_ok;
      enc_word = {imm[11:0], rs1, f3, rd, 7'b0010011};
    end else if (op <= 6'd16) begin
      // Shift amount lives in imm[4:0]; srai is distinguished by instr[30].
      imm_ok   = (imm[31:5] == '0);
      enc_word = {(op == 6'd16) ? 7'h20 : 7'h00, imm[4:0], rs1, f3, rd, 7'b0010011};
    end else if (op <= 6'd23) begin
      imm_ok   = i_ok;
      enc_word = {imm[11:0], rs1, f3, rd, 7'b0000011};
    end else if (op <= 6'd26) begin
      imm_ok   = i_ok;
      enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    end else if (op <= 6'd32) begin
      imm_ok   = b_ok;
      enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    end else if (op == 6'd33) begin
      imm_ok   = j_ok;
      enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    end else if (op == 6'd34) begin
      imm_ok   = i_ok;
      enc_word = {imm[11:0], rs1, 3'd0, rd, 7'b1100111};
    end else if ((op == 6'd35) || (op == 6'd36)) begin
      imm_ok   = (imm[11:0] == '0);
      enc_word = {imm[31:12], rd, (op == 6'd35) ? 7'b0110111 : 7'b0010111};
    end else begin
      op_ok = 1'b0;
    end
  end

  assign in_ready = (state_q == S_LOAD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    err_code_d  = err_code_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (start) begin
      // start overrides any coincident accept; that word is dropped.
      state_d    = S_LOAD;
      wptr_d     = '0;
      count_d    = '0;
      err_code_d = 2'd0;
    end else begin
      if (mem_we_q) count_d = count_q + ONE;
      if (accept) begin
        if (!op_ok) begin
          state_d    = S_ERROR;
          err_code_d = 2'd1;
        end else if (!imm_ok) begin
          state_d    = S_ERROR;
          err_code_d = 2'd2;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wptr_q[ADDR_W-1:0];
          mem_wdata_d = enc_word;
          wptr_d      = wptr_q + ONE;
          if (in_last) begin
            state_d = S_DONE;
          end else if (wptr_q == LAST_ADDR) begin
            state_d    = S_ERROR;
            err_code_d = 2'd3;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      count_q     <= '0;
      err_code_q  <= 2'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      err_code_q  <= err_code_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == S_LOAD);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERROR);
  assign err_code  = err_code_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: full-size instance plus a 4-word instance for overflow cases.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, start, start2, in_valid, in_valid2, in_last;
  logic [5:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  err_code;
  logic [8:0]  count;

  logic        in_ready2, mem_we2, busy2, done2, err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [1:0]  err_code2;
  logic [2:0]  count2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int          log_cyc[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [31:0] log2_addr[$];

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .count(count)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_last(in_last), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .busy(busy2),
    .done(done2), .err(err2), .err_code(err_code2), .count(count2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      log_cyc.push_back(cyc);
      log_addr.push_back(32'(mem_addr));
      log_data.push_back(mem_wdata);
    end
    if (mem_we2) log2_addr.push_back(32'(mem_addr2));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [5:0] o, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im, input logic lst);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; in_last = lst;
  endtask

  task automatic send(input logic [5:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im, input logic lst);
    set_ins(o, d, s1, s2, im, lst);
    in_valid = 1'b1;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic check_reset(input string p);
    check({p, "_in_ready"},  32'(in_ready),  32'd0);
    check({p, "_mem_we"},    32'(mem_we),    32'd0);
    check({p, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({p, "_mem_wdata"}, mem_wdata,      32'd0);
    check({p, "_busy"},      32'(busy),      32'd0);
    check({p, "_done"},      32'(done),      32'd0);
    check({p, "_err"},       32'(err),       32'd0);
    check({p, "_err_code"},  32'(err_code),  32'd0);
    check({p, "_count"},     32'(count),     32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    set_ins(6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    tick(); tick();
    check_reset("rst");
    reset = 1'b0;
    tick();

    // Single add, last.
    do_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_rdy",  32'(in_ready), 32'd1);
    clear_log();
    send(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    in_valid = 1'b0;
    check("add_we",    32'(mem_we), 32'd1);
    check("add_addr",  32'(mem_addr), 32'd0);
    check("add_data",  mem_wdata, 32'h002081B3);
    check("add_done",  32'(done), 32'd1);
    check("add_rdy",   32'(in_ready), 32'd0);
    tick();
    check("add_we_off", 32'(mem_we), 32'd0);
    check("add_count",  32'(count), 32'd1);

    // Back-to-back stream.
    do_start();
    clear_log();
    send(6'd1,  5'd5, 5'd6, 5'd7, 32'd0, 1'b0);
    send(6'd10, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
    send(6'd26, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    send(6'd27, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b1);
    in_valid = 1'b0;
    tick(); tick();
    check("strm_n", 32'(log_data.size()), 32'd4);
    if (log_data.size() == 4) begin
      check("strm_d0", log_data[0], 32'h407302B3);
      check("strm_d1", log_data[1], 32'hFFF00093);
      check("strm_d2", log_data[2], 32'h0020A423);
      check("strm_d3", log_data[3], 32'hFE208CE3);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("strm_a%0d", i), log_addr[i], 32'(i));
        check($sformatf("strm_c%0d", i), 32'(log_cyc[i] - log_cyc[0]), 32'(i));
      end
    end
    check("strm_count", 32'(count), 32'd4);
    check("strm_done",  32'(done), 32'd1);

    // U / J / shift formats.
    do_start();
    clear_log();
    send(6'd35, 5'd1, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
    send(6'd33, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
    send(6'd16, 5'd4, 5'd4, 5'd0, 32'd3, 1'b1);
    in_valid = 1'b0;
    tick();
    check("uj_n", 32'(log_data.size()), 32'd3);
    if (log_data.size() == 3) begin
      check("lui",  log_data[0], 32'h123450B7);
      check("jal",  log_data[1], 32'h001000EF);
      check("srai", log_data[2], 32'h40325213);
    end

    // Error cases: one legal word first so count has something to hold.
    for (int k = 0; k < 3; k++) begin
      do_start();
      clear_log();
      send(6'd10, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
      case (k)
        0:       send(6'd40, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
        1:       send(6'd10, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        default: send(6'd27, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
      endcase
      in_valid = 1'b0;
      check($sformatf("err%0d_err", k),  32'(err), 32'd1);
      check($sformatf("err%0d_code", k), 32'(err_code), (k == 0) ? 32'd1 : 32'd2);
      check($sformatf("err%0d_we", k),   32'(mem_we), 32'd0);
      check($sformatf("err%0d_rdy", k),  32'(in_ready), 32'd0);
      tick();
      check($sformatf("err%0d_count", k), 32'(count), 32'd1);
      check($sformatf("err%0d_nwr", k),   32'(log_data.size()), 32'd1);
    end

    // start coinciding with an accept drops the word and clears count.
    do_start();
    send(6'd10, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    set_ins(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("sw_we",    32'(mem_we), 32'd0);
    check("sw_busy",  32'(busy), 32'd1);
    check("sw_count", 32'(count), 32'd0);
    tick();
    check("sw_count2", 32'(count), 32'd0);

    // Overflow on the 4-word instance.
    log2_addr.delete();
    start2 = 1'b1; tick(); start2 = 1'b0;
    set_ins(6'd10, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
    in_valid2 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    in_valid2 = 1'b0;
    tick(); tick();
    check("ovf_n",     32'(log2_addr.size()), 32'd4);
    for (int i = 0; i < log2_addr.size(); i++) check($sformatf("ovf_a%0d", i), log2_addr[i], 32'(i));
    check("ovf_err",   32'(err2), 32'd1);
    check("ovf_code",  32'(err_code2), 32'd3);
    check("ovf_rdy",   32'(in_ready2), 32'd0);
    check("ovf_count", 32'(count2), 32'd4);

    log2_addr.delete();
    start2 = 1'b1; tick(); start2 = 1'b0;
    in_valid2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_ins(6'd10, 5'd1, 5'd0, 5'd0, 32'd1, (i == 3));
      tick();
    end
    in_valid2 = 1'b0;
    tick(); tick();
    check("full_n",     32'(log2_addr.size()), 32'd4);
    check("full_done",  32'(done2), 32'd1);
    check("full_err",   32'(err2), 32'd0);
    check("full_count", 32'(count2), 32'd4);

    // Reset mid-stream.
    do_start();
    clear_log();
    send(6'd10, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
    send(6'd10, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0);
    set_ins(6'd10, 5'd3, 5'd0, 5'd0, 32'd3, 1'b0);
    reset = 1'b1;
    tick();
    check_reset("mid");
    check("mid_nwr", 32'(log_data.size()), 32'd2);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    do_start();
    clear_log();
    send(6'd10, 5'd4, 5'd0, 5'd0, 32'd4, 1'b1);
    in_valid = 1'b0;
    check("rst_we",   32'(mem_we), 32'd1);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", mem_wdata, 32'h00400213);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
